// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the iterative RV32M multiply/divide unit
// Contents: funct3 operation enum, FSM state enum, divide-by-zero quotient and INT_MIN constants.
package muldiv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [XLEN-1:0] DIV_ZERO_Q = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN    = {1'b1, {(XLEN-1){1'b0}}};

endpackage

// File: rtl/muldiv_paso.sv
// rtl/muldiv_paso.sv - one combinational iteration of shift-add multiply or restoring divide
// Ports: is_div selects divide step; hi_in/lo_in are the accumulator halves; op_in is the
//        multiplicand (multiply) or divisor (divide); hi_out/lo_out are the updated halves.
module muldiv_paso #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] op_in,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic             borrow;
    logic [WIDTH-1:0] trial;

    always_comb begin
        // Multiply: lo holds the remaining multiplier bits; add the multiplicand when lsb set,
        // then shift the whole {carry, hi, lo} right by one.
        sum     = {1'b0, hi_in} + (lo_in[0] ? {1'b0, op_in} : '0);
        // Divide: {hi, lo} shifts left; hi is the partial remainder, lo collects quotient bits.
        shifted = {hi_in, lo_in[WIDTH-1]};
        borrow  = (shifted < {1'b0, op_in});
        // When no borrow the difference is below the divisor, so it fits in WIDTH bits.
        trial   = shifted[WIDTH-1:0] - op_in;

        if (!is_div) begin
            hi_out = sum[WIDTH:1];
            lo_out = {sum[0], lo_in[WIDTH-1:1]};
        end else if (!borrow) begin
            hi_out = trial;
            lo_out = {lo_in[WIDTH-2:0], 1'b1};
        end else begin
            hi_out = shifted[WIDTH-1:0];
            lo_out = {lo_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_iterativo.sv
// rtl/muldiv_iterativo.sv - iterative RV32M multiply/divide unit with start/busy/done handshake
// Ports: CLK, RESET (sync, active-high); start/funct3/operandA/operandB/rdIn request;
//        busy, done, result, rdOut, regWrite (= done) towards the register file write port.
// Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero and signed-overflow requests skip CALC.
module muldiv_iterativo
    import muldiv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic [4:0]       rdIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       rdOut,
    output logic             regWrite
);

    localparam int CNT_W = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    funct3_e          op_q, op_d;
    logic [4:0]       rd_q, rd_d, rd_out_q, rd_out_d;
    logic             sign_a_q, sign_a_d, neg_q, neg_d;
    logic             div0_q, div0_d, ovf_q, ovf_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opb_q, opb_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d, done_q, done_d;

    // Request decode straight from the register-file read ports.
    funct3_e          req_op;
    logic             req_sign_a, req_sign_b, req_is_div, req_div0, req_ovf;
    logic [WIDTH-1:0] req_abs_a, req_abs_b;

    assign req_op     = funct3_e'(funct3);
    assign req_is_div = funct3[2];
    assign req_sign_a = operandA[WIDTH-1] &&
                        (req_op == F3_MULH || req_op == F3_MULHSU ||
                         req_op == F3_DIV  || req_op == F3_REM);
    assign req_sign_b = operandB[WIDTH-1] &&
                        (req_op == F3_MULH || req_op == F3_DIV || req_op == F3_REM);
    assign req_abs_a  = req_sign_a ? -operandA : operandA;
    assign req_abs_b  = req_sign_b ? -operandB : operandB;
    assign req_div0   = req_is_div && (operandB == '0);
    assign req_ovf    = (req_op == F3_DIV || req_op == F3_REM) &&
                        (operandA == INT_MIN) && (operandB == DIV_ZERO_Q);

    logic [WIDTH-1:0] step_hi, step_lo;

    muldiv_paso #(.WIDTH(WIDTH)) u_paso (
        .is_div (op_q[2]),
        .hi_in  (hi_q),
        .lo_in  (lo_q),
        .op_in  (opb_q),
        .hi_out (step_hi),
        .lo_out (step_lo)
    );

    // Sign correction and result selection used in FIX.
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix, fix_val;

    always_comb begin
        prod     = {hi_q, lo_q};
        prod_fix = neg_q ? -prod : prod;
        // Divide-by-zero quotient is all ones regardless of operand signs.
        quot_fix = div0_q ? DIV_ZERO_Q : (ovf_q ? INT_MIN : (neg_q ? -lo_q : lo_q));
        // On divide-by-zero hi holds |dividend|, so the sign fix restores the dividend.
        rem_fix  = ovf_q ? '0 : (sign_a_q ? -hi_q : hi_q);
        case (op_q)
            F3_MUL:                          fix_val = prod_fix[WIDTH-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:    fix_val = prod_fix[2*WIDTH-1:WIDTH];
            F3_DIV, F3_DIVU:                 fix_val = quot_fix;
            default:                         fix_val = rem_fix;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= F3_MUL;
            rd_q     <= '0;
            rd_out_q <= '0;
            sign_a_q <= 1'b0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rd_out_q <= rd_out_d;
            sign_a_q <= sign_a_d;
            neg_q    <= neg_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef MULDIV_EARLY_OUT_EN
                    state_d = (req_div0 || req_ovf) ? FIX : CALC;
`else
                    state_d = CALC;
`endif
                end
            end
            CALC:    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath logic. done/busy are registered, so the visible done pulse
    // lands in the cycle after the DONE state.
    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        rd_d     = rd_q;
        sign_a_d = sign_a_q;
        neg_d    = neg_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        result_d = result_q;
        rd_out_d = rd_out_q;
        busy_d   = (state_d != IDLE);
        done_d   = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = req_op;
                    rd_d     = rdIn;
                    sign_a_d = req_sign_a;
                    neg_d    = req_sign_a ^ req_sign_b;
                    div0_d   = req_div0;
                    ovf_d    = req_ovf;
                    cnt_d    = '0;
                    hi_d     = '0;
                    if (req_is_div) begin
                        lo_d  = req_abs_a;
                        opb_d = req_abs_b;
`ifdef MULDIV_EARLY_OUT_EN
                        // CALC is skipped, so preload what it would have left in hi.
                        if (req_div0) hi_d = req_abs_a;
`endif
                    end else begin
                        lo_d  = req_abs_b;
                        opb_d = req_abs_a;
                    end
                end
            end
            CALC: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 1'b1;
            end
            FIX:     result_d = fix_val;
            DONE:    rd_out_d = rd_q;
            default: ;
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign regWrite = done_q;
    assign result   = result_q;
    assign rdOut    = rd_out_q;

endmodule

// File: tb/tb_muldiv_iterativo.sv
// tb/tb_muldiv_iterativo.sv - self-checking scoreboard bench for muldiv_iterativo
module tb_muldiv_iterativo;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic [4:0]  rdIn;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rdOut;
    logic        regWrite;

    muldiv_iterativo dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .start    (start),
        .funct3   (funct3),
        .operandA (operandA),
        .operandB (operandB),
        .rdIn     (rdIn),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .rdOut    (rdOut),
        .regWrite (regWrite)
    );

    always #5 CLK = ~CLK;

    localparam int LAT = 34;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_SPECIAL = 2;
`else
    localparam int LAT_SPECIAL = 34;
`endif

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
    } exp_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    exp_t sb[$];
    vec_t vq[$];

    int passed = 0;
    int total  = 0;

    int          lat;
    logic        seen;
    logic        busy0;
    logic [31:0] obs_res;
    logic [4:0]  obs_rd;
    logic        obs_rw;

    function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] r);
        vec_t v;
        v.f3 = f3; v.a = a; v.b = b; v.r = r;
        return v;
    endfunction

    // Drive one request at the current negedge, record expectation, scramble inputs after accept.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_res);
        exp_t e;
        e.res = exp_res;
        e.rd  = rd;
        sb.push_back(e);
        funct3   = f3;
        operandA = a;
        operandB = b;
        rdIn     = rd;
        start    = 1'b1;
        @(posedge CLK);
        #1;
        start    = 1'b0;
        operandA = $urandom;
        operandB = $urandom;
        rdIn     = 5'($urandom);
        funct3   = 3'($urandom);
    endtask

    // lat counts accepting-edge-relative edges; sampled at negedges.
    task automatic wait_done();
        lat = 0;
        @(negedge CLK);
        busy0 = busy;
        while (done !== 1'b1 && lat < 60) begin
            @(negedge CLK);
            lat++;
        end
        seen    = (done === 1'b1);
        obs_res = result;
        obs_rd  = rdOut;
        obs_rw  = regWrite;
    endtask

    task automatic test_reset();
        RESET = 1'b1; start = 1'b0; funct3 = '0; operandA = '0; operandB = '0; rdIn = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        total++; if (regWrite !== 1'b0) $display("FAIL reset_regwrite got %b want 0", regWrite); else passed++;
        total++; if (result !== 32'h0) $display("FAIL reset_result got %h want 0", result); else passed++;
        total++; if (rdOut !== 5'h0) $display("FAIL reset_rdout got %h want 0", rdOut); else passed++;
        // RESET and start on the same edge: RESET wins.
        start = 1'b1; funct3 = 3'b000; operandA = 32'd3; operandB = 32'd4; rdIn = 5'd7;
        @(negedge CLK);
        RESET = 1'b0; start = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL reset_start_busy got %b want 0", busy); else passed++;
    endtask

    task automatic test_mul();
        exp_t e;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
        wait_done();
        e = sb.pop_front();
        total++; if (busy0 !== 1'b1) $display("FAIL mul_busy got %b want 1", busy0); else passed++;
        total++; if (seen !== 1'b1) $display("FAIL mul_done_timeout got %b want 1", seen); else passed++;
        total++; if (lat !== LAT) $display("FAIL mul_latency got %0d want %0d", lat, LAT); else passed++;
        total++; if (obs_res !== e.res) $display("FAIL mul_result got %h want %h", obs_res, e.res); else passed++;
        total++; if (obs_rd !== e.rd) $display("FAIL mul_rdout got %0d want %0d", obs_rd, e.rd); else passed++;
        total++; if (obs_rw !== 1'b1) $display("FAIL mul_regwrite got %b want 1", obs_rw); else passed++;
        @(negedge CLK);
        total++; if (done !== 1'b0) $display("FAIL mul_done_pulse got %b want 0", done); else passed++;
        total++; if (regWrite !== 1'b0) $display("FAIL mul_regwrite_pulse got %b want 0", regWrite); else passed++;
    endtask

    task automatic test_mulh();
        exp_t e;
        vq = {};
        vq.push_back(mk(3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000));
        vq.push_back(mk(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000));
        vq.push_back(mk(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF));
        vq.push_back(mk(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000));
        vq.push_back(mk(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001));
        foreach (vq[i]) begin
            issue(vq[i].f3, vq[i].a, vq[i].b, 5'(i + 10), vq[i].r);
            wait_done();
            e = sb.pop_front();
            total++; if (seen !== 1'b1) $display("FAIL mulh[%0d]_timeout got %b want 1", i, seen); else passed++;
            total++; if (lat !== LAT) $display("FAIL mulh[%0d]_latency got %0d want %0d", i, lat, LAT); else passed++;
            total++; if (obs_res !== e.res) $display("FAIL mulh[%0d]_result got %h want %h", i, obs_res, e.res); else passed++;
            total++; if (obs_rd !== e.rd) $display("FAIL mulh[%0d]_rdout got %0d want %0d", i, obs_rd, e.rd); else passed++;
        end
    endtask

    task automatic test_div();
        exp_t e;
        vq = {};
        vq.push_back(mk(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD));
        vq.push_back(mk(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF));
        vq.push_back(mk(3'b101, 32'd100, 32'd7, 32'd14));
        vq.push_back(mk(3'b111, 32'd100, 32'd7, 32'd2));
        vq.push_back(mk(3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD));
        vq.push_back(mk(3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1));
        foreach (vq[i]) begin
            issue(vq[i].f3, vq[i].a, vq[i].b, 5'(i + 1), vq[i].r);
            wait_done();
            e = sb.pop_front();
            total++; if (seen !== 1'b1) $display("FAIL div[%0d]_timeout got %b want 1", i, seen); else passed++;
            total++; if (lat !== LAT) $display("FAIL div[%0d]_latency got %0d want %0d", i, lat, LAT); else passed++;
            total++; if (obs_res !== e.res) $display("FAIL div[%0d]_result got %h want %h", i, obs_res, e.res); else passed++;
            total++; if (obs_rd !== e.rd) $display("FAIL div[%0d]_rdout got %0d want %0d", i, obs_rd, e.rd); else passed++;
        end
    endtask

    task automatic test_div_special();
        exp_t e;
        vq = {};
        vq.push_back(mk(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF));
        vq.push_back(mk(3'b110, 32'd5, 32'd0, 32'd5));
        vq.push_back(mk(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000));
        vq.push_back(mk(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000));
        vq.push_back(mk(3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF));
        vq.push_back(mk(3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB));
        vq.push_back(mk(3'b101, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF));
        vq.push_back(mk(3'b111, 32'h8000_0000, 32'd0, 32'h8000_0000));
        foreach (vq[i]) begin
            issue(vq[i].f3, vq[i].a, vq[i].b, 5'(i + 20), vq[i].r);
            wait_done();
            e = sb.pop_front();
            total++; if (seen !== 1'b1) $display("FAIL special[%0d]_timeout got %b want 1", i, seen); else passed++;
            total++; if (lat !== LAT_SPECIAL) $display("FAIL special[%0d]_latency got %0d want %0d", i, lat, LAT_SPECIAL); else passed++;
            total++; if (obs_res !== e.res) $display("FAIL special[%0d]_result got %h want %h", i, obs_res, e.res); else passed++;
            total++; if (obs_rd !== e.rd) $display("FAIL special[%0d]_rdout got %0d want %0d", i, obs_rd, e.rd); else passed++;
        end
    endtask

    task automatic test_start_ignored();
        exp_t        e;
        int          dcnt;
        int          first_lat;
        logic [31:0] r;
        logic [4:0]  rd;
        dcnt = 0; first_lat = -1; r = '0; rd = '0;
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFE);
        for (int c = 0; c <= 45; c++) begin
            @(negedge CLK);
            if (c == 10) begin
                start = 1'b1; funct3 = 3'b101; operandA = 32'd9; operandB = 32'd3; rdIn = 5'd1;
            end
            if (c == 11) start = 1'b0;
            if (done === 1'b1) begin
                dcnt++;
                if (first_lat < 0) begin
                    first_lat = c; r = result; rd = rdOut;
                end
            end
        end
        e = sb.pop_front();
        total++; if (dcnt !== 1) $display("FAIL ignore_done_count got %0d want 1", dcnt); else passed++;
        total++; if (first_lat !== LAT) $display("FAIL ignore_latency got %0d want %0d", first_lat, LAT); else passed++;
        total++; if (r !== e.res) $display("FAIL ignore_result got %h want %h", r, e.res); else passed++;
        total++; if (rd !== e.rd) $display("FAIL ignore_rdout got %0d want %0d", rd, e.rd); else passed++;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        issue(3'b101, 32'd100, 32'd7, 5'd2, 32'd14);
        wait_done();
        e = sb.pop_front();
        total++; if (obs_res !== e.res) $display("FAIL b2b_first_result got %h want %h", obs_res, e.res); else passed++;
        // Issue in the done cycle: the unit is already back in IDLE.
        issue(3'b111, 32'd100, 32'd7, 5'd3, 32'd2);
        wait_done();
        e = sb.pop_front();
        total++; if (lat !== LAT) $display("FAIL b2b_latency got %0d want %0d", lat, LAT); else passed++;
        total++; if (obs_res !== e.res) $display("FAIL b2b_second_result got %h want %h", obs_res, e.res); else passed++;
        total++; if (obs_rd !== e.rd) $display("FAIL b2b_second_rdout got %0d want %0d", obs_rd, e.rd); else passed++;
    endtask

    task automatic test_reset_mid_op();
        exp_t e;
        int   dcnt;
        dcnt = 0;
        issue(3'b101, 32'd1000, 32'd3, 5'd4, 32'd333);
        for (int c = 0; c < 20; c++) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL abort_done got %b want 0", done); else passed++;
        total++; if (result !== 32'h0) $display("FAIL abort_result got %h want 0", result); else passed++;
        total++; if (rdOut !== 5'h0) $display("FAIL abort_rdout got %h want 0", rdOut); else passed++;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (done === 1'b1) dcnt++;
        end
        e = sb.pop_front();
        total++; if (dcnt !== 0) $display("FAIL abort_no_done got %0d want 0", dcnt); else passed++;
        issue(3'b000, 32'd6, 32'd7, 5'd9, 32'd42);
        wait_done();
        e = sb.pop_front();
        total++; if (seen !== 1'b1) $display("FAIL after_abort_timeout got %b want 1", seen); else passed++;
        total++; if (lat !== LAT) $display("FAIL after_abort_latency got %0d want %0d", lat, LAT); else passed++;
        total++; if (obs_res !== e.res) $display("FAIL after_abort_result got %h want %h", obs_res, e.res); else passed++;
        total++; if (obs_rd !== e.rd) $display("FAIL after_abort_rdout got %0d want %0d", obs_rd, e.rd); else passed++;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_div_special();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/muldiv_iterativo.md
Name: muldiv_iterativo

Overview:
- Iterative RV32M multiply/divide unit; sits directly downstream of the register file.
- Consumes readData1/readData2 as operandA/operandB and returns a result plus writeback info (rd, RegWrite) to the register file write port.
- Multi-cycle, start/busy/done handshake; core stalls while busy.

Parameters:
- WIDTH, 32, operand/result width (RV32; only 32 is supported by the core).
- CNT_W, $clog2(WIDTH), iteration counter width (derived, not overridden).

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- operandA  input  WIDTH  rs1 value (dividend / multiplicand).
- operandB  input  WIDTH  rs2 value (divisor / multiplier).
- rdIn  input  5  destination register.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; result, rdOut and regWrite are valid.
- result  output  WIDTH  operation result; held until next accepted start.
- rdOut  output  5  latched rdIn.
- regWrite  output  1  equals done; goes to the register file RegWrite. x0 is filtered by the register file.

Behaviour:
- One clock, CLK. Reset is synchronous, active-high, port RESET.
- Reset values: state IDLE, busy 0, done 0, regWrite 0, result 0, rdOut 0, counter 0.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE, start=1: latch funct3, rdIn, sign flags, and absolute values of the operands (signed ops only; MULHSU takes abs of A only). Go to CALC; busy=1 next cycle.
- CALC: WIDTH iterations, one per cycle.
  - MUL*: radix-2 shift-add into a 2*WIDTH accumulator.
  - DIV*/REM*: restoring shift-subtract.
  - After the iteration with counter = WIDTH-1, go to FIX.
- FIX: apply sign correction.
  - Product negated if signs differ (per op signedness).
  - Quotient negated if signs differ.
  - Remainder takes the dividend sign.
  - Select low half (MUL), high half (MULH*), quotient, or remainder.
  - Go to DONE.
- DONE: done=1, regWrite=1, busy=0, result valid. Next state IDLE.
- Latency: start sampled at edge k -> done high in the cycle following edge k+WIDTH+2 (34 cycles for WIDTH=32). Throughput is one op per WIDTH+3 cycles.
- Back-to-back: start is ignored in CALC, FIX and DONE. It is not queued.
- Operands and rdIn may change after the accepting edge without effect.
- Divide by zero (DIV/DIVU): quotient = all ones. REM/REMU = dividend. No trap.
- Signed overflow, DIV -2^31 / -1: quotient = 0x8000_0000, REM = 0.
- Negation uses two's complement on WIDTH bits; MULH on -2^31 * -2^31 = 0x4000_0000.
- RESET mid-operation: abort on that edge; all outputs return to reset values and no done pulse is produced.
- RESET and start on the same edge: RESET wins.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- Defined: in IDLE, a divide-by-zero or DIV/REM signed-overflow request skips CALC and goes IDLE->FIX->DONE. done appears 2 cycles after the accepting edge, with the same result values as above.
- Undefined: every op takes the full WIDTH+2 latency.
- Results are identical in both builds; only latency differs.

Decomposition:
- Package muldiv_pkg:
  - funct3 encoding enum (MUL..REMU).
  - state enum (IDLE, CALC, FIX, DONE).
  - Constants DIV_ZERO_Q (all ones) and INT_MIN (0x8000_0000).
- Sub-module muldiv_paso: combinational single iteration (add-or-pass for multiply, trial subtract for divide). It is instantiated once in CALC.

Test Plan:
- MUL 7 * -3, rd=5 -> done exactly 34 cycles after the start edge; result 0xFFFF_FFEB; rdOut 5; regWrite 1 for one cycle.
- MULH / MULHSU / MULHU with A=0x8000_0000, B=0xFFFF_FFFF -> 0x0000_0000 / 0x8000_0000 / 0x7FFF_FFFF.
- DIV -7/2 -> 0xFFFF_FFFD. REM -7/2 -> 0xFFFF_FFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFF_FFFF. REM 5/0 -> 5. DIV 0x8000_0000/-1 -> 0x8000_0000. REM -> 0.
  - Latency is 34 cycles without MULDIV_EARLY_OUT_EN and 2 cycles with it.
- start re-asserted at cycle 10 of an op -> ignored, single done pulse. RESET at cycle 20 -> busy 0 next cycle, no done; a new op afterwards completes correctly.
